// File: rtl/pcpi_dispatch_pkg.sv
// PCPI dispatch shared types, slot constants and the first-ready select.
// Used by the dispatcher, its interface and the claim timer.
package pcpi_dispatch_pkg;

    localparam int XLEN      = 32;
    localparam int SLOT_MUL  = 0;
    localparam int SLOT_DIV  = 1;
    localparam int NUM_SLOTS = 2;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DONE,
        REJECT,
        DRAIN
    } state_t;

    // Lowest-index ready slot wins; MUL is the fallback index.
    function automatic logic [SLOT_W-1:0] first_ready(
        input logic [NUM_SLOTS-1:0] rdy
    );
        logic [SLOT_W-1:0] idx;
        idx = SLOT_W'(SLOT_MUL);
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (rdy[i]) idx = SLOT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcpi_dispatch_if.sv
// PCPI bundle: core request/response side plus per-slot coprocessor side.
// master = core and coprocessors, slave = the dispatcher.
interface pcpi_dispatch_if;
    import pcpi_dispatch_pkg::*;

    logic                      core_valid;
    logic [XLEN-1:0]           core_insn;
    logic [XLEN-1:0]           core_rs1;
    logic [XLEN-1:0]           core_rs2;
    logic                      core_wr;
    logic [XLEN-1:0]           core_rd;
    logic                      core_wait;
    logic                      core_ready;

    logic [NUM_SLOTS-1:0]      cop_valid;
    logic [XLEN-1:0]           cop_insn;
    logic [XLEN-1:0]           cop_rs1;
    logic [XLEN-1:0]           cop_rs2;
    logic [NUM_SLOTS-1:0]      cop_wr;
    logic [NUM_SLOTS*XLEN-1:0] cop_rd;
    logic [NUM_SLOTS-1:0]      cop_wait;
    logic [NUM_SLOTS-1:0]      cop_ready;

    modport master (
        output core_valid, core_insn, core_rs1, core_rs2,
        input  core_wr, core_rd, core_wait, core_ready,
        input  cop_valid, cop_insn, cop_rs1, cop_rs2,
        output cop_wr, cop_rd, cop_wait, cop_ready
    );

    modport slave (
        input  core_valid, core_insn, core_rs1, core_rs2,
        output core_wr, core_rd, core_wait, core_ready,
        output cop_valid, cop_insn, cop_rs1, cop_rs2,
        input  cop_wr, cop_rd, cop_wait, cop_ready
    );

endinterface

// File: rtl/pcpi_claim_timer.sv
// Saturating claim counter; expired flags the last cycle before rejection.
// Clear has priority over enable; the count never wraps.
module pcpi_claim_timer #(
    parameter int CLAIM_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(CLAIM_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles, holding at CLAIM_CYCLES.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != CW'(CLAIM_CYCLES)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CW'(CLAIM_CYCLES - 1));

endmodule

// File: rtl/pcpi_dispatch.sv
// Routes one PCPI request to MUL (slot 0) / DIV (slot 1) and returns the first response.
// Optional checkers: define PCPI_DISPATCH_CHECK_EN for sticky collision/spurious flags.
module pcpi_dispatch
    import pcpi_dispatch_pkg::*;
#(
    parameter int CLAIM_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    pcpi_dispatch_if.slave bus,
    output logic         err_collision,
    output logic         err_spurious
);

    state_t            state_q;
    state_t            state_d;
    logic              any_wait;
    logic              any_ready;
    logic              expired;
    logic              in_issue;
    logic              cap;
    logic              rej;
    logic [SLOT_W-1:0] sel;
    logic [XLEN-1:0]   rd_q;
    logic              wr_q;
    logic              wait_q;

    assign any_wait  = |bus.cop_wait;
    assign any_ready = |bus.cop_ready;
    assign in_issue  = (state_q == ISSUE);
    assign sel       = first_ready(bus.cop_ready);

    pcpi_claim_timer #(
        .CLAIM_CYCLES(CLAIM_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (!in_issue || any_wait),
        .en     (in_issue),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: abort beats ready, ready beats claim timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.core_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (!bus.core_valid)          state_d = IDLE;
                else if (any_ready)           state_d = DONE;
                else if (expired && !any_wait) state_d = REJECT;
            end
            DONE: begin
                state_d = DRAIN;
            end
            REJECT, DRAIN: begin
                if (!bus.core_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap = in_issue && (state_d == DONE);
    assign rej = in_issue && (state_d == REJECT);

    // Result capture, registered wait, wr cleared on rejection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            wait_q <= in_issue && (state_d == ISSUE) && any_wait;
            if (cap) begin
                rd_q <= bus.cop_rd[XLEN*int'(sel) +: XLEN];
                wr_q <= bus.cop_wr[sel];
            end else if (rej) begin
                wr_q <= 1'b0;
            end
        end
    end

    assign bus.cop_valid  = in_issue ? '1 : '0;
    assign bus.cop_insn   = bus.core_insn;
    assign bus.cop_rs1    = bus.core_rs1;
    assign bus.cop_rs2    = bus.core_rs2;
    assign bus.core_ready = (state_q == DONE);
    assign bus.core_wait  = wait_q;
    assign bus.core_rd    = rd_q;
    assign bus.core_wr    = wr_q;

`ifdef PCPI_DISPATCH_CHECK_EN
    logic coll_q;
    logic spur_q;

    // Sticky protocol error flags and the ready/wait exclusivity check.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_q <= 1'b0;
            spur_q <= 1'b0;
        end else begin
            if (&bus.cop_ready)          coll_q <= 1'b1;
            if (any_ready && !in_issue)  spur_q <= 1'b1;
            assert (!(bus.core_ready && bus.core_wait));
        end
    end

    assign err_collision = coll_q;
    assign err_spurious  = spur_q;
`else
    assign err_collision = 1'b0;
    assign err_spurious  = 1'b0;
`endif

endmodule
